mips_cpu_register_file_param: RTL

MIPS_CPU_REGISTER_FILE_PARAM -- requirements
Module: mips_cpu_register_file_param

---
 rtl/mips_cpu_register_file_param.sv | 92 +++++++++
 1 files changed

// File: rtl/mips_cpu_register_file_param.sv
// Parameterised MIPS register file: multi-port combinational reads, optional
// write-to-read forwarding, and a per-register pending (load scoreboard) bit.
module mips_cpu_register_file_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned V0_INDEX   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_reg,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_reg,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0]            read_data_v0,
  input  logic                             pending_set,
  input  logic [ADDR_WIDTH-1:0]            pending_reg,
  output logic [READ_PORTS-1:0]            read_busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] V0Addr = ADDR_WIDTH'(V0_INDEX);
  localparam bit BypassEn = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [Depth-1:0]      pending_q, pending_d;
  logic                  write_valid;

  // Register 0 is hardwired: never written, never marked pending.
  assign write_valid = write_enable && (write_reg != '0);

  always_comb begin
    pending_d = pending_q;
    if (write_valid) begin
      pending_d[write_reg] = 1'b0;
    end
    // Applied after the write clear so a same-cycle new load wins.
    if (pending_set && (pending_reg != '0)) begin
      pending_d[pending_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      if (write_valid) begin
        regs_q[write_reg] <= write_data;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;

    assign addr = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = BypassEn && write_valid && (write_reg == addr);

    always_comb begin
      if (addr == '0) begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (hit) begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = write_data;
      end else begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
      end
    end

    assign read_busy[p] = (addr != '0) && pending_q[addr] && !hit;
  end

  logic v0_hit;
  assign v0_hit = BypassEn && write_valid && (write_reg == V0Addr);

  always_comb begin
    if (V0Addr == '0) begin
      read_data_v0 = '0;
    end else if (v0_hit) begin
      read_data_v0 = write_data;
    end else begin
      read_data_v0 = regs_q[V0Addr];
    end
  end

endmodule
